// File: rtl/seq_alu.sv
// seq_alu -- sequential signed ALU with valid/ready handshakes.
//
// Single-cycle ops (ADD, SUB, PASS_A, PASS_B, AND, OR, SLT, illegal and
// divide-by-zero) produce a result one cycle after acceptance. MUL and DIV
// iterate for WIDTH cycles in BUSY. The result is held in DONE until the
// consumer takes it.
//
// Optional feature macro: SEQ_ALU_DIV_EN
//   defined   -> iterative restoring divider present
//   undefined -> divider logic absent, DIV opcode is reported as illegal
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   op_a, op_b            signed WIDTH-bit operands
//   control               4-bit opcode
//   out_valid / out_ready result handshake
//   data_out              2*WIDTH-bit result
//   sign_flag, zero_flag, div0_flag, illegal_flag   result status
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WIDTH-1:0]   op_a,
   input  logic signed [WIDTH-1:0]   op_b,
   input  logic [3:0]                control,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*WIDTH-1:0]        data_out,
   output logic                      sign_flag,
   output logic                      zero_flag,
   output logic                      div0_flag,
   output logic                      illegal_flag
);

   localparam int DW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_DIV   = 4'b0010;
   localparam logic [3:0] OP_MUL   = 4'b0011;
   localparam logic [3:0] OP_PASSB = 4'b0100;
   localparam logic [3:0] OP_PASSA = 4'b0101;
   localparam logic [3:0] OP_AND   = 4'b0110;
   localparam logic [3:0] OP_OR    = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic signed [DW-1:0] sext(input logic signed [WIDTH-1:0] v);
      return {{WIDTH{v[WIDTH-1]}}, v};
   endfunction

   // Magnitude of a signed value; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   state_t                    r_state, w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic [DW-1:0]             r_data;
   logic                      r_sign, r_zero, r_div0, r_ill;

   // iteration operands: unsigned magnitudes plus result sign
   logic [DW-1:0]             r_acc, r_mcand;
   logic [WIDTH-1:0]          r_mplier;
   logic                      r_neg;

   logic signed [DW-1:0]      w_imm;
   logic                      w_imm_ill, w_imm_dz, w_iter, w_last;
   logic [DW-1:0]             w_acc_nxt, w_mul_res, w_fin;

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH-1:0]          r_rem, r_quo, r_dvs;
   logic                      r_is_div, r_a_neg;
   logic [WIDTH:0]            w_shift, w_trial;
   logic [WIDTH-1:0]          w_rem_nxt, w_quo_nxt, w_rem_fin, w_quo_fin;
`endif

   assign in_ready     = (r_state == IDLE);
   assign out_valid    = (r_state == DONE);
   assign data_out     = r_data;
   assign sign_flag    = r_sign;
   assign zero_flag    = r_zero;
   assign div0_flag    = r_div0;
   assign illegal_flag = r_ill;
   assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));

   // decode and single-cycle results, computed straight from the request
   always_comb begin
      w_imm     = '0;
      w_imm_ill = 1'b0;
      w_imm_dz  = 1'b0;
      w_iter    = 1'b0;
      case (control)
         OP_ADD:   w_imm = sext(op_a) + sext(op_b);
         OP_SUB:   w_imm = sext(op_a) - sext(op_b);
         OP_MUL:   w_iter = 1'b1;
         OP_PASSB: w_imm = sext(op_b);
         OP_PASSA: w_imm = sext(op_a);
         OP_AND:   w_imm = sext(op_a) & sext(op_b);
         OP_OR:    w_imm = sext(op_a) | sext(op_b);
         OP_SLT:   w_imm = {{(DW-1){1'b0}}, (op_a < op_b)};
         OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
            if (op_b == '0) begin
               w_imm    = {op_a, {WIDTH{1'b1}}};
               w_imm_dz = 1'b1;
            end else begin
               w_iter = 1'b1;
            end
`else
            w_imm_ill = 1'b1;
`endif
         end
         default:  w_imm_ill = 1'b1;
      endcase
   end

   // shift-add multiply step on magnitudes
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mul_res = r_neg ? -w_acc_nxt : w_acc_nxt;

`ifdef SEQ_ALU_DIV_EN
   // restoring divide step: remainder stays below the divisor, so the trial
   // difference is negative exactly when its top bit is set
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_trial   = w_shift - {1'b0, r_dvs};
   assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
   assign w_quo_fin = r_neg   ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fin = r_a_neg ? -w_rem_nxt : w_rem_nxt;
   assign w_fin     = r_is_div ? {w_rem_fin, w_quo_fin} : w_mul_res;
`else
   assign w_fin     = w_mul_res;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = w_iter ? BUSY : DONE;
         BUSY:    if (w_last) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // result register and flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_data <= '0;
         r_sign <= 1'b0;
         r_zero <= 1'b0;
         r_div0 <= 1'b0;
         r_ill  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_cnt <= '0;
               if (!w_iter) begin
                  r_data <= w_imm;
                  r_sign <= w_imm[DW-1];
                  r_zero <= (w_imm == '0);
                  r_div0 <= w_imm_dz;
                  r_ill  <= w_imm_ill;
               end
            end
            BUSY: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_data <= w_fin;
                  r_sign <= w_fin[DW-1];
                  r_zero <= (w_fin == '0);
                  r_div0 <= 1'b0;
                  r_ill  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // iteration datapath; loaded on accept, frozen outside BUSY
   always_ff @(posedge clk) begin
      if (r_state == IDLE && in_valid) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, mag(op_a)};
         r_mplier <= mag(op_b);
         r_neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`ifdef SEQ_ALU_DIV_EN
         r_rem    <= '0;
         r_quo    <= mag(op_a);
         r_dvs    <= mag(op_b);
         r_is_div <= (control == OP_DIV);
         r_a_neg  <= op_a[WIDTH-1];
`endif
      end else if (r_state == BUSY) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
`ifdef SEQ_ALU_DIV_EN
         r_rem    <= w_rem_nxt;
         r_quo    <= w_quo_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH=16. Expectations for DIV follow
// whether SEQ_ALU_DIV_EN is defined for the build.
module tb_seq_alu;

   localparam int W = 16;

   localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, DIV = 4'b0010, MUL = 4'b0011,
                          PSB = 4'b0100, PSA = 4'b0101, AND = 4'b0110, ORR = 4'b0111,
                          SLT = 4'b1000, BAD = 4'b1111;

   logic                clk = 1'b0;
   logic                rst_n, in_valid, out_ready;
   logic                in_ready, out_valid;
   logic signed [W-1:0] op_a, op_b;
   logic [3:0]          control;
   logic [2*W-1:0]      data_out;
   logic                sign_flag, zero_flag, div0_flag, illegal_flag;

   int n_tests = 0;
   int n_fail  = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .control(control),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out),
      .sign_flag(sign_flag), .zero_flag(zero_flag),
      .div0_flag(div0_flag), .illegal_flag(illegal_flag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {sign_flag, zero_flag, div0_flag, illegal_flag};
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      op_a = a; op_b = b; control = op; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ret"}, {out_valid, in_ready}, 2'b01);
   endtask

   // flags argument order: {sign, zero, div0, illegal}
   task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op, input logic [2*W-1:0] exp_d, input logic [3:0] exp_f);
      issue(a, b, op);
      check({tag, "_vld"}, {out_valid, in_ready}, 2'b10);
      check({tag, "_data"}, data_out, exp_d);
      check({tag, "_flags"}, flags(), exp_f);
      drain(tag);
   endtask

   task automatic iter(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op, input logic [2*W-1:0] exp_d, input logic [3:0] exp_f);
      issue(a, b, op);
      repeat (W - 1) tick();
      check({tag, "_early"}, {out_valid, in_ready}, 2'b00);
      tick();
      check({tag, "_vld"}, out_valid, 1'b1);
      check({tag, "_data"}, data_out, exp_d);
      check({tag, "_flags"}, flags(), exp_f);
      drain(tag);
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; control = '0;
      tick(); tick();
      check("rst_hs", {in_ready, out_valid}, 2'b10);
      check("rst_data", data_out, 32'h0);
      check("rst_flags", flags(), 4'b0000);
      rst_n = 1'b1;
      tick();

      single("add_ovf", 16'h7FFF, 16'h0001, ADD, 32'h0000_8000, 4'b0000);
      single("sub_neg", 16'h8000, 16'h0001, SUB, 32'hFFFF_7FFF, 4'b1000);
      single("slt_t",   16'hFFFF, 16'h0001, SLT, 32'h0000_0001, 4'b0000);
      single("slt_f",   16'h0005, 16'hFFFB, SLT, 32'h0000_0000, 4'b0100);
      single("and",     16'h8000, 16'hFFFF, AND, 32'hFFFF_8000, 4'b1000);
      single("or",      16'h00F0, 16'h0F00, ORR, 32'h0000_0FF0, 4'b0000);
      single("pass_a",  16'h8001, 16'h1234, PSA, 32'hFFFF_8001, 4'b1000);
      single("pass_b",  16'h8001, 16'h1234, PSB, 32'h0000_1234, 4'b0000);
      single("illegal", 16'h1111, 16'h2222, BAD, 32'h0000_0000, 4'b0101);

      // MUL -3*7 with operand churn and in_valid during BUSY
      issue(16'hFFFD, 16'h0007, MUL);
      op_a = 16'h0100; op_b = 16'h0100; control = ADD; in_valid = 1'b1;
      repeat (W - 1) tick();
      check("mul_early", {out_valid, in_ready}, 2'b00);
      tick();
      in_valid = 1'b0;
      check("mul_vld", out_valid, 1'b1);
      check("mul_data", data_out, 32'hFFFF_FFEB);
      check("mul_flags", flags(), 4'b1000);
      drain("mul");

      iter("mul_min", 16'h8000, 16'h8000, MUL, 32'h4000_0000, 4'b0000);
      iter("mul_max", 16'h7FFF, 16'h7FFF, MUL, 32'h3FFF_0001, 4'b0000);
      iter("mul_zero", 16'h0000, 16'h0005, MUL, 32'h0000_0000, 4'b0100);

`ifdef SEQ_ALU_DIV_EN
      iter("div_neg", 16'hFFF9, 16'h0002, DIV, 32'hFFFF_FFFD, 4'b1000);
      iter("div_negb", 16'h0007, 16'hFFFE, DIV, 32'h0001_FFFD, 4'b0000);
      single("div0", 16'h0064, 16'h0000, DIV, 32'h0064_FFFF, 4'b0010);
`else
      single("div_neg", 16'hFFF9, 16'h0002, DIV, 32'h0000_0000, 4'b0101);
      single("div0", 16'h0064, 16'h0000, DIV, 32'h0000_0000, 4'b0101);
`endif

      // hold in DONE for 5 cycles with ignored requests
      issue(16'h0005, 16'h0006, ADD);
      for (int i = 0; i < 5; i++) begin
         op_a = 16'h0064; op_b = 16'h0001; control = ADD;
         in_valid = (i % 2 == 0);
         tick();
         check("hold_vld", out_valid, 1'b1);
         check("hold_data", data_out, 32'h0000_000B);
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_noacc", {out_valid, in_ready}, 2'b01);
      tick();
      in_valid = 1'b0;
      check("hold_next_vld", out_valid, 1'b1);
      check("hold_next_data", data_out, 32'h0000_0065);
      drain("hold_next");

      // reset in BUSY cycle 5 of a MUL
      issue(16'h0003, 16'h0007, MUL);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_hs", {in_ready, out_valid}, 2'b10);
      check("abort_data", data_out, 32'h0);
      check("abort_flags", flags(), 4'b0000);
      seen = 1'b0;
      repeat (2 * W + 4) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("abort_stale", seen, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal values 8..32.
REQ-002 Reset is synchronous, active-low (rst_n), on a single clock (clk).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op_a, op_b  input  WIDTH each  signed two's-complement operands.
REQ-008 control  input  4  operation code (REQ-013).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 data_out  output  2*WIDTH  result.
REQ-012 sign_flag, zero_flag, div0_flag, illegal_flag  output  1 each  result status.

Function
REQ-013 Opcodes: 0000 ADD, 0001 SUB, 0010 DIV, 0011 MUL, 0100 PASS_B, 0101 PASS_A, 0110 AND, 0111 OR, 1000 SLT; all others illegal.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE: in_valid=1 captures op_a, op_b, control; ADD/SUB/PASS/AND/OR/SLT/illegal/DIV-by-zero go to DONE next cycle; MUL/DIV go to BUSY.
REQ-016 ADD/SUB/PASS/AND/OR operate on operands sign-extended to 2*WIDTH; no overflow wrap at WIDTH.
REQ-017 SLT: data_out=1 if op_a<op_b (signed), else 0.
REQ-018 MUL: iterative signed multiply, one partial-product step per cycle, exactly WIDTH cycles in BUSY; data_out = full 2*WIDTH signed product.
REQ-019 DIV: iterative restoring divide, exactly WIDTH cycles in BUSY; quotient truncated toward zero in data_out[WIDTH-1:0], remainder (sign of dividend) in data_out[2*WIDTH-1:WIDTH].
REQ-020 DIV with op_b=0: no BUSY; quotient all ones, remainder=op_a, div0_flag=1.
REQ-021 Illegal opcode: data_out=0, illegal_flag=1.
REQ-022 sign_flag=data_out[2*WIDTH-1]; zero_flag=(data_out==0); both valid whenever out_valid=1.
REQ-023 DONE: out_valid=1; data_out and all flags held stable until out_ready=1.
REQ-024 DONE with out_ready=1: transition to IDLE; no new request accepted in that same cycle.
REQ-025 in_valid while not IDLE is ignored; operand changes during BUSY/DONE do not affect the result.
REQ-026 Latency from accept to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV.

Reset
REQ-027 rst_n=0 at a clock edge forces IDLE, in_ready=1 after reset, out_valid=0, data_out=0, all flags=0, iteration counter=0.
REQ-028 Reset during BUSY or DONE aborts the operation; no result is delivered.

Configuration
REQ-029 Macro SEQ_ALU_DIV_EN: defined -> DIV implemented per REQ-019/020.
REQ-030 SEQ_ALU_DIV_EN undefined -> divider logic absent; DIV treated as illegal opcode (REQ-021), 1-cycle latency, div0_flag always 0.

Verification (WIDTH=16)
REQ-031 ADD 0x7FFF+0x0001 -> data_out=0x00008000, sign_flag=0, zero_flag=0, latency 1.
REQ-032 MUL -3*7 -> after 17 cycles data_out=0xFFFFFFEB, sign_flag=1.
REQ-033 DIV -7/2 (DIV_EN) -> after 17 cycles data_out=0xFFFFFFFD (rem 0xFFFF, quot 0xFFFD); without DIV_EN -> data_out=0, illegal_flag=1 after 1 cycle.
REQ-034 DIV 100/0 -> data_out=0x0064FFFF, div0_flag=1, latency 1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_valid and data_out stable; in_valid pulses ignored; accept only after return to IDLE.
REQ-036 rst_n=0 at BUSY cycle 5 of MUL -> next cycle IDLE, out_valid=0, data_out=0; no stale result afterwards.
